// File: rtl/dmr_counter_checker.sv
// Dual-modular-redundant counter pair with a mismatch-tracking fault FSM.
// Define DMR_FAULT_INJECT_EN to add the inj_valid/inj_mask upset ports.
module dmr_counter_checker #(
    parameter int WIDTH          = 4,
    parameter int MISMATCH_LIMIT = 3,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 clear_fault,
`ifdef DMR_FAULT_INJECT_EN
    input  logic                 inj_valid,
    input  logic [WIDTH-1:0]     inj_mask,
`endif
    output logic [WIDTH-1:0]     cnt_a,
    output logic [WIDTH-1:0]     cnt_b,
    output logic                 mismatch,
    output logic                 fault,
    output logic [1:0]           state,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SUSPECT = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;
    localparam logic [7:0] LIMIT      = 8'(MISMATCH_LIMIT);

    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] b_flip;
    logic [7:0]       run_len;
    logic [7:0]       run_nxt;
    logic [7:0]       run_inc;
    logic [1:0]       state_nxt;
    logic             err_inc;

    assign mismatch = (cnt_a != cnt_b);
    assign fault    = (state == ST_FAULT);
    assign run_inc  = run_len + 8'd1;

`ifdef DMR_FAULT_INJECT_EN
    assign b_flip = inj_valid ? inj_mask : '0;
`else
    assign b_flip = '0;
`endif

    // Each copy advances from its own register so an upset persists.
    always_comb begin
        a_nxt = cnt_a;
        b_nxt = cnt_b;
        if (fault) begin
            if (clear_fault) begin
                a_nxt = '0;
                b_nxt = '0;
            end
        end else begin
            if (load) begin
                a_nxt = load_val;
                b_nxt = load_val;
            end else if (en) begin
                a_nxt = cnt_a + WIDTH'(1);
                b_nxt = cnt_b + WIDTH'(1);
            end
            b_nxt = b_nxt ^ b_flip;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run_len;
        err_inc   = 1'b0;
        case (state)
            ST_RUN: begin
                if (mismatch) begin
                    err_inc = 1'b1;
                    if (LIMIT == 8'd1) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        state_nxt = ST_SUSPECT;
                        run_nxt   = 8'd1;
                    end
                end
            end
            ST_SUSPECT: begin
                if (mismatch) begin
                    run_nxt = run_inc;
                    if (run_inc >= LIMIT) begin
                        state_nxt = ST_FAULT;
                    end
                end else begin
                    state_nxt = ST_RUN;
                    run_nxt   = 8'd0;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_nxt = ST_RUN;
                    run_nxt   = 8'd0;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                run_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_a     <= '0;
            cnt_b     <= '0;
            state     <= ST_RUN;
            run_len   <= 8'd0;
            err_count <= '0;
        end else begin
            cnt_a   <= a_nxt;
            cnt_b   <= b_nxt;
            state   <= state_nxt;
            run_len <= run_nxt;
            if (err_inc && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmr_counter_checker.sv
// Randomized directed bench for dmr_counter_checker with a spec-level model.
// Define DMR_FAULT_INJECT_EN to also exercise the injection ports.
module tb_dmr_counter_checker;

    localparam int LIMIT = 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       clear_fault;
    logic       inj_valid;
    logic [3:0] inj_mask;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic       mismatch;
    logic       fault;
    logic [1:0] state;
    logic [7:0] err_count;

    logic [3:0] m_a;
    logic [3:0] m_b;
    int         m_state;
    int         m_run;
    int         m_err;
    logic [3:0] fv;

    int tests = 0;
    int fails = 0;

    dmr_counter_checker #(
        .WIDTH(4),
        .MISMATCH_LIMIT(LIMIT),
        .ERR_CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .load(load),
        .load_val(load_val),
        .clear_fault(clear_fault),
`ifdef DMR_FAULT_INJECT_EN
        .inj_valid(inj_valid),
        .inj_mask(inj_mask),
`endif
        .cnt_a(cnt_a),
        .cnt_b(cnt_b),
        .mismatch(mismatch),
        .fault(fault),
        .state(state),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(m_a));
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(m_b));
        chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_a != m_b));
        chk({tag, ".fault"}, 32'(fault), 32'(m_state == 2));
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".err"}, 32'(err_count), 32'(m_err));
    endtask

    // Reference behaviour written from the rules, one clock edge at a time.
    task automatic model_step();
        logic [3:0] na;
        logic [3:0] nb;
        bit         mm;
        if (!reset) begin
            m_a = 0; m_b = 0; m_state = 0; m_run = 0; m_err = 0;
        end else if (m_state == 2) begin
            if (clear_fault) begin
                m_a = 0; m_b = 0; m_state = 0; m_run = 0;
            end
        end else begin
            mm = (m_a != m_b);
            na = load ? load_val : en ? 4'((int'(m_a) + 1) % 16) : m_a;
            nb = load ? load_val : en ? 4'((int'(m_b) + 1) % 16) : m_b;
            if (inj_valid) nb = nb ^ inj_mask;
            if (m_state == 0) begin
                if (mm) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    if (LIMIT == 1) m_state = 2;
                    else begin m_state = 1; m_run = 1; end
                end
            end else if (mm) begin
                m_run = m_run + 1;
                if (m_run >= LIMIT) m_state = 2;
            end else begin
                m_state = 0; m_run = 0;
            end
            m_a = na;
            m_b = nb;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        en = 0; load = 0; clear_fault = 0; inj_valid = 0;
    endtask

    // Emulates a single-event upset on the shadow copy.
    task automatic flip(input logic [3:0] mask);
        idle();
        fv = m_b ^ mask;
        force dut.cnt_b = fv;
        m_b = fv;
        cycle();
        release dut.cnt_b;
    endtask

    task automatic do_reset();
        reset = 0; en = 1; load = 1; clear_fault = 1;
        load_val = 4'd7;
        cycle();
        reset = 1;
        idle();
    endtask

    initial begin
        reset = 0; en = 1; load = 1; load_val = 4'd5;
        clear_fault = 1; inj_valid = 0; inj_mask = 4'd0;
        m_a = 4'hx; m_b = 4'hx; m_state = 0; m_run = 0; m_err = 0;
        @(negedge clk);
        cycle();
        cycle();
        check_all("reset");
        reset = 1;
        idle();

        en = 1;
        for (int i = 0; i < 17; i++) begin
            cycle();
            check_all("count");
        end
        chk("count17.cnt_a", 32'(cnt_a), 32'd1);
        chk("count17.state", 32'(state), 32'd0);

        load = 1; en = 1; load_val = 4'd9;
        cycle();
        chk("load_wins.cnt_a", 32'(cnt_a), 32'd9);
        chk("load_wins.cnt_b", 32'(cnt_b), 32'd9);
        idle();

        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom);
            load = ($urandom_range(0, 3) == 0);
            load_val = 4'($urandom);
            cycle();
            check_all("rand_run");
        end

        idle();
        flip(4'b0001);
        check_all("flip");
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all("to_fault");
        end
        chk("fault_reached", 32'(fault), 32'd1);
        for (int i = 0; i < 5; i++) begin
            en = 1; load = 1; load_val = 4'($urandom);
            cycle();
            check_all("frozen");
        end
        idle();
        clear_fault = 1;
        cycle();
        check_all("clear");
        chk("clear.cnt_a", 32'(cnt_a), 32'd0);
        chk("clear.err_kept", 32'(err_count), 32'd1);
        idle();

        clear_fault = 1; en = 1;
        cycle();
        check_all("clear_in_run");
        idle();

        flip(4'b0100);
        load = 1; load_val = 4'($urandom);
        cycle();
        check_all("resync_load");
        idle();
        cycle();
        check_all("resync_run");
        chk("resync.state", 32'(state), 32'd0);

        flip(4'b0010);
        reset = 0; en = 1; load = 1; clear_fault = 1;
        cycle();
        check_all("reset_suspect");
        chk("reset_suspect.err", 32'(err_count), 32'd0);
        reset = 1;
        idle();

`ifdef DMR_FAULT_INJECT_EN
        inj_valid = 1; inj_mask = 4'b0001;
        cycle();
        idle();
        check_all("inj");
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all("inj_fault");
        end
        chk("inj.fault", 32'(fault), 32'd1);
        chk("inj.err", 32'(err_count), 32'd1);
        do_reset();
        cycle();
        inj_valid = 1; inj_mask = 4'b1000; en = 1;
        cycle();
        idle();
        load = 1; load_val = 4'd3;
        cycle();
        check_all("inj_resync");
        idle();
        cycle();
        check_all("inj_back");
        chk("inj_back.err", 32'(err_count), 32'd1);
        do_reset();
`endif

        do_reset();
        for (int i = 0; i < 260; i++) begin
            flip(4'($urandom_range(1, 15)));
            load = 1; load_val = 4'($urandom);
            cycle();
            idle();
            cycle();
        end
        check_all("saturate");
        chk("saturate.err", 32'(err_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
